// File: rtl/serial_xnor_compare.sv
// Frame-based serial equality checker: counts XNOR mismatches over a fixed-length frame and
// reports whole-frame equality plus the mismatch count at end of frame.
module serial_xnor_compare #(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in1,
  input  logic             in2,
  output logic             match_bit,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic [CNT_W-1:0] mismatch_cnt
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(FRAME_LEN - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             equal_q, equal_d;
  logic             busy_q, done_q;
  logic             mis;
  logic             accept;
  logic [CNT_W-1:0] cnt_inc;

  assign match_bit = ~(in1 ^ in2);
  assign mis       = ~match_bit;
  assign accept    = (state_q == StRun) && in_valid;
  // Kept as a separate 1-bit signal so the cast zero-extends rather than widening the inversion.
  assign cnt_inc   = cnt_q + CNT_W'(mis);

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_q;
    equal_d   = equal_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StRun;
          bit_idx_d = '0;
          cnt_d     = '0;
          equal_d   = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (accept) begin
          bit_idx_d = bit_idx_q + 1'b1;
          cnt_d     = cnt_inc;
          if (bit_idx_q == LastIdx) begin
            state_d = StDone;
            equal_d = (cnt_inc == '0);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bit_idx_q <= '0;
      cnt_q     <= '0;
      equal_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      cnt_q     <= cnt_d;
      equal_q   <= equal_d;
      busy_q    <= (state_d == StRun);
      done_q    <= (state_d == StDone);
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign equal        = equal_q;
  assign mismatch_cnt = cnt_q;

endmodule
